// File: rtl/spike_argmax_seq_if.sv
// Handshake bundle for spike_argmax_seq: spike-count vector in, argmax result out.
// ARGMAX_MARGIN_EN adds the margin_o field.
interface spike_argmax_seq_if #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned COUNT_W     = 8
);
  localparam int unsigned IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  logic                           in_valid_i;
  logic                           in_ready_o;
  logic [NUM_CLASSES*COUNT_W-1:0] counts_i;
  logic                           out_valid_o;
  logic                           out_ready_i;
  logic [IDX_W-1:0]               class_o;
  logic [COUNT_W-1:0]             max_count_o;
  logic                           tie_o;
  logic                           none_o;
  logic                           busy_o;
`ifdef ARGMAX_MARGIN_EN
  logic [COUNT_W-1:0]             margin_o;

  modport slave (
    input  in_valid_i, counts_i, out_ready_i,
    output in_ready_o, out_valid_o, class_o, max_count_o, tie_o, none_o, busy_o, margin_o
  );
  modport master (
    output in_valid_i, counts_i, out_ready_i,
    input  in_ready_o, out_valid_o, class_o, max_count_o, tie_o, none_o, busy_o, margin_o
  );
`else
  modport slave (
    input  in_valid_i, counts_i, out_ready_i,
    output in_ready_o, out_valid_o, class_o, max_count_o, tie_o, none_o, busy_o
  );
  modport master (
    output in_valid_i, counts_i, out_ready_i,
    input  in_ready_o, out_valid_o, class_o, max_count_o, tie_o, none_o, busy_o
  );
`endif
endinterface

// File: rtl/spike_argmax_seq.sv
// Sequential argmax over NUM_CLASSES spike counts, one compare per cycle.
// Optional ARGMAX_MARGIN_EN adds a runner-up tracker and the winner-minus-runner-up margin.
module spike_argmax_seq #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned COUNT_W     = 8,
  parameter int unsigned MIN_COUNT   = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  spike_argmax_seq_if.slave  bus
);
  localparam int unsigned IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int unsigned VEC_W = NUM_CLASSES * COUNT_W;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t             state_q;
  logic [VEC_W-1:0]   counts_q;
  logic [IDX_W-1:0]   idx_q;
  logic [COUNT_W-1:0] max_q;
  logic [IDX_W-1:0]   class_q;
  logic               tie_q;
  logic               none_q;
  logic               out_valid_q;
  logic               in_ready_q;
  logic               busy_q;

  logic [COUNT_W-1:0] cur_c;
  logic [COUNT_W-1:0] first_c;
  logic [COUNT_W-1:0] nxt_max;
  logic [IDX_W-1:0]   nxt_class;
  logic               nxt_tie;
  logic               gt;
  logic               scan_last;
  logic               accept_in;
  logic               accept_out;

`ifdef ARGMAX_MARGIN_EN
  logic [COUNT_W-1:0] second_q;
  logic [COUNT_W-1:0] margin_q;
  logic [COUNT_W-1:0] nxt_second;
`endif

  function automatic logic below_min(input logic [COUNT_W-1:0] x);
    return (MIN_COUNT != 0) && (32'(x) < MIN_COUNT);
  endfunction

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    cur_c      = counts_q[int'(idx_q)*COUNT_W +: COUNT_W];
    first_c    = bus.counts_i[COUNT_W-1:0];
    gt         = cur_c > max_q;
    nxt_max    = gt ? cur_c : max_q;
    nxt_class  = gt ? idx_q : class_q;
    nxt_tie    = gt ? 1'b0 : ((cur_c == max_q) ? 1'b1 : tie_q);
    scan_last  = (idx_q == IDX_W'(NUM_CLASSES - 1));
    accept_in  = bus.in_valid_i && in_ready_q;
    accept_out = out_valid_q && bus.out_ready_i;
`ifdef ARGMAX_MARGIN_EN
    nxt_second = gt ? max_q : ((cur_c > second_q) ? cur_c : second_q);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      counts_q    <= '0;
      idx_q       <= '0;
      max_q       <= '0;
      class_q     <= '0;
      tie_q       <= 1'b0;
      none_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
      second_q    <= '0;
      margin_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_in) begin
            counts_q   <= bus.counts_i;
            max_q      <= first_c;
            class_q    <= '0;
            tie_q      <= 1'b0;
            idx_q      <= IDX_W'(1);
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= '0;
`endif
            // A single class has nothing to scan: the capture is the result.
            if (NUM_CLASSES == 1) begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              none_q      <= below_min(first_c);
`ifdef ARGMAX_MARGIN_EN
              margin_q    <= first_c;
`endif
            end else begin
              state_q <= SCAN;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        SCAN: begin
          max_q   <= nxt_max;
          class_q <= nxt_class;
          tie_q   <= nxt_tie;
          idx_q   <= idx_q + IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
          second_q <= nxt_second;
`endif
          if (scan_last) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            none_q      <= below_min(nxt_max);
`ifdef ARGMAX_MARGIN_EN
            margin_q    <= nxt_tie ? '0 : (nxt_max - nxt_second);
`endif
          end
        end
        DONE: begin
          if (accept_out) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.class_o     = class_q;
  assign bus.max_count_o = max_q;
  assign bus.tie_o       = tie_q;
  assign bus.none_o      = none_q;
  assign bus.busy_o      = busy_q;
`ifdef ARGMAX_MARGIN_EN
  assign bus.margin_o    = margin_q;
`endif
endmodule

// File: tb/tb_spike_argmax_seq.sv
// Scoreboard bench for spike_argmax_seq: a 10-class instance and a 1-class instance,
// checked against a sort-based argmax reference model.
module tb_spike_argmax_seq;
  localparam int unsigned N    = 10;
  localparam int unsigned W    = 8;
  localparam int unsigned MINC = 1;
  localparam int unsigned SW   = 4;

  typedef struct {
    int cls;
    int mx;
    int tie;
    int none;
    int margin;
    int cap;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t mq[$];
  exp_t sq[$];
  exp_t me;
  exp_t se;
  logic mprev = 1'b0;
  logic sprev = 1'b0;
  bit   rand_rdy = 1'b0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  spike_argmax_seq_if #(.NUM_CLASSES(N), .COUNT_W(W))  mbus ();
  spike_argmax_seq_if #(.NUM_CLASSES(1), .COUNT_W(SW)) sbus ();

  spike_argmax_seq #(.NUM_CLASSES(N), .COUNT_W(W), .MIN_COUNT(MINC)) u_main (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (mbus.slave)
  );

  spike_argmax_seq #(.NUM_CLASSES(1), .COUNT_W(SW), .MIN_COUNT(MINC)) u_small (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (sbus.slave)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: winner is the maximum, first index holding it; runner-up from a sorted copy.
  function automatic exp_t model(input int c[$], input int min_count);
    exp_t e;
    int s[$];
    s = c;
    s.rsort();
    e.mx  = s[0];
    e.cls = -1;
    for (int i = 0; i < c.size(); i++)
      if (e.cls < 0 && c[i] == e.mx) e.cls = i;
    e.tie    = (s.size() > 1 && s[1] == s[0]) ? 1 : 0;
    e.none   = (min_count != 0 && e.mx < min_count) ? 1 : 0;
    e.margin = (s.size() > 1) ? (s[0] - s[1]) : s[0];
    e.cap    = 0;
    return e;
  endfunction

  // Result monitors: compare on each rising out_valid against the oldest expectation.
  always @(negedge clk_i) begin
    if (mbus.out_valid_o && !mprev) begin
      if (mq.size() == 0) chk("main_unexpected_valid", 1, 0);
      else begin
        me = mq.pop_front();
        chk("main_class", mbus.class_o, me.cls);
        chk("main_max", mbus.max_count_o, me.mx);
        chk("main_tie", mbus.tie_o, me.tie);
        chk("main_none", mbus.none_o, me.none);
        chk("main_latency", cyc - me.cap, N - 1);
`ifdef ARGMAX_MARGIN_EN
        chk("main_margin", mbus.margin_o, me.margin);
`endif
      end
    end
    mprev <= mbus.out_valid_o;
  end

  always @(negedge clk_i) begin
    if (sbus.out_valid_o && !sprev) begin
      if (sq.size() == 0) chk("small_unexpected_valid", 1, 0);
      else begin
        se = sq.pop_front();
        chk("small_class", sbus.class_o, se.cls);
        chk("small_max", sbus.max_count_o, se.mx);
        chk("small_tie", sbus.tie_o, se.tie);
        chk("small_none", sbus.none_o, se.none);
        chk("small_latency", cyc - se.cap, 0);
`ifdef ARGMAX_MARGIN_EN
        chk("small_margin", sbus.margin_o, se.margin);
`endif
      end
    end
    sprev <= sbus.out_valid_o;
  end

  task automatic send_main(input int c[$], output int cap);
    logic [N*W-1:0] v;
    exp_t e;
    int n;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(c[k]);
    n = 0;
    while (!mbus.in_ready_o && n < 500) begin
      if (rand_rdy) mbus.out_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      n++;
    end
    if (!mbus.in_ready_o) begin
      chk("main_in_ready_timeout", 0, 1);
      cap = 0;
      return;
    end
    mbus.in_valid_i = 1'b1;
    mbus.counts_i   = v;
    @(posedge clk_i);
    #1;
    e     = model(c, MINC);
    e.cap = cyc;
    cap   = cyc;
    mq.push_back(e);
    @(negedge clk_i);
    mbus.in_valid_i = 1'b0;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
    mbus.counts_i = v;
  endtask

  task automatic send_small(input int c);
    int q[$];
    exp_t e;
    int n;
    n = 0;
    while (!sbus.in_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    if (!sbus.in_ready_o) begin
      chk("small_in_ready_timeout", 0, 1);
      return;
    end
    sbus.in_valid_i = 1'b1;
    sbus.counts_i   = SW'(c);
    @(posedge clk_i);
    #1;
    q.push_back(c);
    e     = model(q, MINC);
    e.cap = cyc;
    sq.push_back(e);
    @(negedge clk_i);
    sbus.in_valid_i = 1'b0;
    sbus.counts_i   = SW'($urandom);
  endtask

  task automatic gen_counts(output int c[$]);
    int mode;
    c.delete();
    mode = $urandom_range(0, 2);
    for (int k = 0; k < N; k++)
      case (mode)
        0:       c.push_back($urandom_range(0, 255));
        1:       c.push_back($urandom_range(0, 3));
        default: c.push_back($urandom_range(250, 255));
      endcase
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((mq.size() != 0 || sq.size() != 0) && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_pending", mq.size() + sq.size(), 0);
  endtask

  task automatic check_main_zero(input string tag);
    chk({tag, "_valid"}, mbus.out_valid_o, 0);
    chk({tag, "_in_ready"}, mbus.in_ready_o, 0);
    chk({tag, "_busy"}, mbus.busy_o, 0);
    chk({tag, "_class"}, mbus.class_o, 0);
    chk({tag, "_max"}, mbus.max_count_o, 0);
    chk({tag, "_tie"}, mbus.tie_o, 0);
    chk({tag, "_none"}, mbus.none_o, 0);
`ifdef ARGMAX_MARGIN_EN
    chk({tag, "_margin"}, mbus.margin_o, 0);
`endif
  endtask

  initial begin
    int   c[$];
    int   cap1;
    int   cap2;
    int   n;
    exp_t e;
    logic [N*W-1:0] v;

    mbus.in_valid_i  = 1'b0;
    mbus.counts_i    = '0;
    mbus.out_ready_i = 1'b1;
    sbus.in_valid_i  = 1'b0;
    sbus.counts_i    = '0;
    sbus.out_ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_main_zero("reset");
    chk("reset_small_valid", sbus.out_valid_o, 0);
    chk("reset_small_max", sbus.max_count_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("main_in_ready_after_reset", mbus.in_ready_o, 1);
    chk("small_in_ready_after_reset", sbus.in_ready_o, 1);

    // Directed vectors: mixed with a late tie, all zeros, single top at the last index.
    c = '{3, 7, 2, 9, 1, 0, 4, 9, 5, 8};
    send_main(c, cap1);
    c.delete();
    for (int k = 0; k < N; k++) c.push_back(0);
    send_main(c, cap1);
    c.delete();
    for (int k = 0; k < N; k++) c.push_back((k == N - 1) ? 255 : 254);
    send_main(c, cap1);
    drain();

    // Back-to-back throughput with out_ready held high.
    gen_counts(c);
    send_main(c, cap1);
    gen_counts(c);
    send_main(c, cap2);
    chk("main_throughput", cap2 - cap1, N + 1);
    drain();

    rand_rdy = 1'b1;
    repeat (40) begin
      gen_counts(c);
      send_main(c, cap1);
    end
    rand_rdy = 1'b0;
    mbus.out_ready_i = 1'b1;
    drain();

    // Consumer stalls in DONE while new vectors are offered.
    mbus.out_ready_i = 1'b0;
    gen_counts(c);
    e = model(c, MINC);
    send_main(c, cap1);
    n = 0;
    while (!mbus.out_valid_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("stall_valid_seen", mbus.out_valid_o, 1);
    repeat (20) begin
      mbus.in_valid_i = 1'b1;
      for (int k = 0; k < N; k++) v[k*W +: W] = W'($urandom);
      mbus.counts_i = v;
      @(negedge clk_i);
      chk("stall_valid", mbus.out_valid_o, 1);
      chk("stall_in_ready", mbus.in_ready_o, 0);
      chk("stall_class", mbus.class_o, e.cls);
      chk("stall_max", mbus.max_count_o, e.mx);
      chk("stall_tie", mbus.tie_o, e.tie);
    end
    mbus.in_valid_i  = 1'b0;
    mbus.out_ready_i = 1'b1;
    @(negedge clk_i);
    chk("accept_valid_drop", mbus.out_valid_o, 0);
    chk("accept_in_ready", mbus.in_ready_o, 1);
    chk("accept_busy", mbus.busy_o, 0);
    chk("accept_class_kept", mbus.class_o, e.cls);
    chk("accept_max_kept", mbus.max_count_o, e.mx);
    repeat (3) @(negedge clk_i);
    chk("stall_no_extra_result", mq.size(), 0);

    // Reset while the scan is at index 4 discards the vector.
    gen_counts(c);
    send_main(c, cap1);
    repeat (3) @(negedge clk_i);
    chk("midscan_busy", mbus.busy_o, 1);
    mq.delete();
    rst_i = 1'b1;
    @(negedge clk_i);
    check_main_zero("midscan_reset");
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("midscan_in_ready", mbus.in_ready_o, 1);
    repeat (15) @(negedge clk_i);
    chk("midscan_no_valid", mbus.out_valid_o, 0);
    gen_counts(c);
    send_main(c, cap1);
    drain();

    // Single-class instance.
    send_small(5);
    send_small(0);
    send_small(15);
    repeat (8) send_small($urandom_range(0, 15));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
